// File: rtl/r_rr_arbiter_param.sv
// r_rr_arbiter_param
// Round-robin arbiter for the AXI read-response channel. Picks one of NUM_SLV slave R streams,
// keeps it on the master port until the burst ends (or every beat when LOCK_BURST=0), and
// rotates priority so the most recent winner is served last next time.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   s_rvalid   per-slave RVALID
//   s_rlast    per-slave RLAST
//   s_rid      per-slave RID, slave i at [i*ID_W +: ID_W]
//   s_rready   per-slave RREADY (only the granted bit can be set)
//   m_rready   master RREADY
//   m_rvalid   granted slave's RVALID
//   m_rlast    granted slave's RLAST
//   r_slv_sel  granted slave index, NUM_SLV when idle
//   id_valid   grant active
//   id         RID captured when the grant was made
module r_rr_arbiter_param #(
  parameter int unsigned NUM_SLV    = 5,
  parameter int unsigned ID_W       = 6,
  parameter bit          LOCK_BURST = 1'b1,
  parameter int unsigned SEL_W      = $clog2(NUM_SLV + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SLV-1:0]      s_rvalid,
  input  logic [NUM_SLV-1:0]      s_rlast,
  input  logic [NUM_SLV*ID_W-1:0] s_rid,
  output logic [NUM_SLV-1:0]      s_rready,
  input  logic                    m_rready,
  output logic                    m_rvalid,
  output logic                    m_rlast,
  output logic [SEL_W-1:0]        r_slv_sel,
  output logic                    id_valid,
  output logic [ID_W-1:0]         id
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               any_req;
  logic               found_hi, found_lo;
  logic [SEL_W-1:0]   win_hi, win_lo, win;
  logic [ID_W-1:0]    win_id;
  logic               rel_evt;

  assign any_req   = |s_rvalid;
  assign id_valid  = (state_q == StGrant);
  assign r_slv_sel = sel_q;
  assign id        = id_q;

  // Rotating search: the first requester at or above ptr wins; if none, the lowest-index
  // requester below ptr wins, which is the wrapped continuation of the same search.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (s_rvalid[i]) begin
        if (!found_hi && (SEL_W'(i) >= ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = SEL_W'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = SEL_W'(i);
        end
      end
    end
    win    = found_hi ? win_hi : win_lo;
    win_id = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (win == SEL_W'(i)) begin
        win_id = s_rid[i*ID_W +: ID_W];
      end
    end
  end

  // Channel mux; everything is forced low while no grant is active.
  always_comb begin
    s_rready = '0;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (id_valid && (sel_q == SEL_W'(i))) begin
        s_rready[i] = m_rready;
        m_rvalid    = s_rvalid[i];
        m_rlast     = s_rlast[i];
      end
    end
  end

  assign rel_evt = id_valid & m_rvalid & m_rready & (m_rlast | ~LOCK_BURST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    id_d    = id_q;
    if ((state_q == StIdle) || rel_evt) begin
      if (any_req) begin
        // Re-arbitrating in the release cycle avoids a bubble between bursts.
        state_d = StGrant;
        sel_d   = win;
        id_d    = win_id;
        ptr_d   = (win == SEL_W'(NUM_SLV - 1)) ? '0 : win + SEL_W'(1);
      end else begin
        state_d = StIdle;
        sel_d   = SEL_W'(NUM_SLV);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= SEL_W'(NUM_SLV);
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_r_rr_arbiter_param.sv
// Bench for r_rr_arbiter_param: two instances (burst-locked and per-beat), directed scenarios
// followed by randomized traffic, all compared against a behavioural model every cycle.
module tb_r_rr_arbiter_param;

  localparam int N = 5;
  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst [2];
  logic [N-1:0]   rv  [2];
  logic [N-1:0]   rl  [2];
  logic [N*W-1:0] rid [2];
  logic           mr  [2];
  logic [N-1:0]   srr [2];
  logic           mv  [2];
  logic           ml  [2];
  logic [2:0]     sel [2];
  logic           idv [2];
  logic [W-1:0]   idq [2];

  r_rr_arbiter_param #(.NUM_SLV(N), .ID_W(W), .LOCK_BURST(1'b1)) dut (
    .clk(clk), .reset(rst[0]), .s_rvalid(rv[0]), .s_rlast(rl[0]), .s_rid(rid[0]),
    .s_rready(srr[0]), .m_rready(mr[0]), .m_rvalid(mv[0]), .m_rlast(ml[0]),
    .r_slv_sel(sel[0]), .id_valid(idv[0]), .id(idq[0])
  );

  r_rr_arbiter_param #(.NUM_SLV(N), .ID_W(W), .LOCK_BURST(1'b0)) dut_nl (
    .clk(clk), .reset(rst[1]), .s_rvalid(rv[1]), .s_rlast(rl[1]), .s_rid(rid[1]),
    .s_rready(srr[1]), .m_rready(mr[1]), .m_rvalid(mv[1]), .m_rlast(ml[1]),
    .r_slv_sel(sel[1]), .id_valid(idv[1]), .id(idq[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: granted flag, owner index, rotation pointer, captured id.
  bit m_gnt [2];
  int m_own [2];
  int m_ptr [2];
  int m_id  [2];

  function automatic int mdl_pick(int k);
    for (int n = 0; n < N; n++) begin
      int i;
      i = (m_ptr[k] + n) % N;
      if (rv[k][i]) return i;
    end
    return -1;
  endfunction

  task automatic mdl_update(int k);
    bit lock;
    bit rel;
    int w;
    lock = (k == 0);
    if (rst[k]) begin
      m_gnt[k] = 0; m_own[k] = N; m_ptr[k] = 0; m_id[k] = 0;
    end else begin
      rel = m_gnt[k] && rv[k][m_own[k]] && mr[k] && (rl[k][m_own[k]] || !lock);
      if (!m_gnt[k] || rel) begin
        w = mdl_pick(k);
        if (w >= 0) begin
          m_gnt[k] = 1;
          m_own[k] = w;
          m_ptr[k] = (w + 1) % N;
          m_id[k]  = int'(rid[k][w*W +: W]);
        end else if (rel) begin
          m_gnt[k] = 0;
          m_own[k] = N;
        end
      end
    end
  endtask

  // Inputs are already driven; check all outputs mid-cycle, then advance one edge.
  task automatic step();
    logic [N-1:0] exp_rr;
    logic exp_mv, exp_ml;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_mv = m_gnt[k] ? rv[k][m_own[k]] : 1'b0;
      exp_ml = m_gnt[k] ? rl[k][m_own[k]] : 1'b0;
      exp_rr = (m_gnt[k] && mr[k]) ? (N'(1) << m_own[k]) : '0;
      chk($sformatf("sel%0d", k), 32'(sel[k]), m_gnt[k] ? m_own[k] : N);
      chk($sformatf("id_valid%0d", k), 32'(idv[k]), 32'(m_gnt[k]));
      chk($sformatf("id%0d", k), 32'(idq[k]), m_id[k]);
      chk($sformatf("m_rvalid%0d", k), 32'(mv[k]), 32'(exp_mv));
      chk($sformatf("m_rlast%0d", k), 32'(ml[k]), 32'(exp_ml));
      chk($sformatf("s_rready%0d", k), 32'(srr[k]), 32'(exp_rr));
    end
    @(posedge clk);
    mdl_update(0);
    mdl_update(1);
    #1;
  endtask

  task automatic drive(int k, bit r, logic [N-1:0] v, logic [N-1:0] l, bit m);
    rst[k] = r; rv[k] = v; rl[k] = l; mr[k] = m; rid[k] = (N*W)'({$urandom, $urandom});
  endtask

  int exp_own [6] = '{1, 3, 1, 3, 1, 3};
  int rem [N];
  logic [W-1:0] id0;

  initial begin
    for (int k = 0; k < 2; k++) drive(k, 1'b1, '1, '0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      mdl_update(0);
      mdl_update(1);
    end
    #1;

    // Reset with every slave requesting.
    step();
    chk("rst_sel", 32'(sel[0]), 5);
    chk("rst_idv", 32'(idv[0]), 0);
    chk("rst_rready", 32'(srr[0]), 0);
    drive(0, 1'b0, '1, '1, 1'b1);
    id0 = rid[0][W-1:0];
    step();
    chk("rst_first_sel", 32'(sel[0]), 0);
    chk("rst_first_id", 32'(idq[0]), 32'(id0));

    // Single-beat rotation with no bubbles.
    for (int j = 1; j <= 5; j++) begin
      drive(0, 1'b0, '1, '1, 1'b1);
      step();
      chk($sformatf("rot_sel_%0d", j), 32'(sel[0]), j % N);
    end

    // Burst lock: slave 2 four beats, slave 3 waiting.
    drive(0, 1'b1, '0, '0, 1'b0);
    step();
    drive(0, 1'b0, 5'b00100, '0, 1'b1);
    step();
    chk("lock_grant", 32'(sel[0]), 2);
    for (int b = 1; b <= 4; b++) begin
      drive(0, 1'b0, 5'b01100, (b == 4) ? 5'b01100 : 5'b00000, 1'b1);
      step();
      chk($sformatf("lock_beat%0d", b), 32'(sel[0]), (b == 4) ? 3 : 2);
    end

    // Backpressure on slave 3 while slave 1 waits.
    id0 = idq[0];
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b0, 5'b01010, 5'b01000, 1'b0);
      step();
      chk("bp_sel", 32'(sel[0]), 3);
      chk("bp_id", 32'(idq[0]), 32'(id0));
      chk("bp_rready", 32'(srr[0]), 0);
    end
    drive(0, 1'b0, 5'b01010, 5'b01000, 1'b1);
    step();
    chk("bp_release", 32'(sel[0]), 1);

    // Reset in the middle of a slave-4 burst.
    drive(0, 1'b1, '0, '0, 1'b0);
    step();
    drive(0, 1'b0, 5'b10000, '0, 1'b1);
    step();
    chk("mid_grant", 32'(sel[0]), 4);
    drive(0, 1'b0, 5'b10000, '0, 1'b1);
    step();
    drive(0, 1'b1, 5'b10000, '0, 1'b1);
    step();
    chk("mid_rst_sel", 32'(sel[0]), 5);
    chk("mid_rst_idv", 32'(idv[0]), 0);
    drive(0, 1'b0, 5'b10001, '0, 1'b1);
    step();
    chk("mid_after_sel", 32'(sel[0]), 0);

    // Per-beat arbitration: slaves 1 and 3 each send three beats.
    drive(0, 1'b1, '0, '0, 1'b0);
    drive(1, 1'b1, '0, '0, 1'b0);
    step();
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[1] = 3;
    rem[3] = 3;
    drive(1, 1'b0, 5'b01010, '0, 1'b1);
    step();
    chk("nl_grant", 32'(sel[1]), exp_own[0]);
    for (int j = 0; j < 6; j++) begin
      logic [N-1:0] v, l;
      v = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
        v[i] = (rem[i] > 0);
        l[i] = (rem[i] == 1);
      end
      drive(1, 1'b0, v, l, 1'b1);
      step();
      rem[exp_own[j]]--;
      if (j < 5) chk($sformatf("nl_beat%0d", j), 32'(sel[1]), exp_own[j + 1]);
    end

    // Randomized traffic on both instances.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, ($urandom_range(0, 49) == 0), N'($urandom), N'($urandom),
              ($urandom_range(0, 3) != 0));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/r_rr_arbiter_param.md
# r_rr_arbiter_param

Parametrised round-robin arbiter for the read-response (R) channel of the AXI node. It selects one of NUM_SLV slave R streams toward a single master port, holds the grant for a whole burst until the RLAST beat is accepted, and rotates priority fairly. It drives the R-data mux select, the granted ID and the per-slave RREADY fan-out.

## Interface
- NUM_SLV, default 5: number of slave R streams, range 2..16.
- ID_W, default 6: RID width.
- LOCK_BURST, default 1: 1 = hold grant until the RLAST handshake; 0 = re-arbitrate after every accepted beat.
- SEL_W, default $clog2(NUM_SLV+1): select width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_rvalid  in  NUM_SLV  per-slave RVALID.
- s_rlast  in  NUM_SLV  per-slave RLAST.
- s_rid  in  NUM_SLV*ID_W  per-slave RID; slave i occupies bits [i*ID_W +: ID_W].
- s_rready  out  NUM_SLV  per-slave RREADY; only the granted bit can be 1.
- m_rready  in  1  master-side RREADY.
- m_rvalid  out  1  the granted slave's RVALID, gated by the grant.
- m_rlast  out  1  the granted slave's RLAST, gated by the grant.
- r_slv_sel  out  SEL_W  index of the granted slave; NUM_SLV when idle.
- id_valid  out  1  grant active.
- id  out  ID_W  RID captured at grant time.

## Operation
- The FSM has two states:
  - IDLE: no grant.
  - GRANT: one slave owns the channel.
- Priority pointer ptr (0..NUM_SLV-1):
  - The winner is the first i with s_rvalid[i]=1, searched from ptr upward and wrapping.
  - On each new grant, ptr <= winner+1 mod NUM_SLV, so the last winner has the lowest priority next time.
- IDLE with any s_rvalid=1: register the winner. State <= GRANT, r_slv_sel <= winner, id <= s_rid[winner], id_valid <= 1.
- GRANT, combinational path:
  - m_rvalid = s_rvalid[sel].
  - m_rlast = s_rlast[sel].
  - s_rready[sel] = m_rready; every other bit is 0.
- Release event: m_rvalid & m_rready & (m_rlast | !LOCK_BURST).
- On release:
  - If any s_rvalid is 1 that cycle, arbitrate immediately using the updated rotation, so there is no bubble. The current owner may win again only if it is the sole requester.
  - Otherwise state <= IDLE, r_slv_sel <= NUM_SLV, id_valid <= 0. id keeps its last value.
- No release while in GRANT: hold sel and id unchanged, regardless of other requests.
- If the owner's s_rvalid drops mid-burst (illegal under AXI), the grant is still held.
- Combinational outputs are all 0 when id_valid=0.

## Timing
- Reset values: state IDLE, ptr 0, r_slv_sel NUM_SLV, id 0, id_valid 0, s_rready 0, m_rvalid 0, m_rlast 0.
- Grant latency: a request seen in IDLE at edge N gives id_valid=1 and sel valid after edge N. The first beat can transfer in the cycle following edge N.
- Back-to-back bursts: the release beat at edge N swaps the grant at edge N, so the next owner's first beat can transfer in the following cycle. Sustained throughput is 1 beat per cycle.
- Reset asserted mid-burst: at the next edge all registers take their reset values. s_rready drops combinationally with the grant.
- Simultaneous requests in IDLE: the winner follows the ptr rotation, not a fixed index priority.
- The ptr search wraps modulo NUM_SLV. NUM_SLV need not be a power of two.

## Test plan
- Reset and idle: assert reset 2 cycles with s_rvalid=5'b11111, then release reset. r_slv_sel=5, id_valid=0 and s_rready=0 during reset. One cycle after release: sel=0, id=s_rid[0].
- Rotation: hold s_rvalid=5'b11111 with single-beat bursts (rlast=1) and m_rready=1. Sel sequence is 0,1,2,3,4,0 with one beat per cycle and no bubbles.
- Burst lock: slave 2 sends a 4-beat burst while slave 3 requests from beat 1. Sel stays 2 for all 4 beats, then becomes 3 the cycle after the RLAST handshake.
- Backpressure: hold m_rready=0 for 3 cycles mid-burst. Sel and id are stable, s_rready[sel]=0, and no release occurs.
- LOCK_BURST=0: two slaves each send 3-beat bursts. Grants alternate on every accepted beat: A,B,A,B,A,B.
- Reset mid-burst: assert reset on beat 2 of a slave-4 burst. Next cycle shows sel=5, id_valid=0, ptr=0. After reset, slave 0 wins the first arbitration.
